// File: rtl/stream_pkg.sv
// Shared definitions for the stream demux slice: FSM state codes,
// default datapath width and the packed {last, data} beat record.
package stream_pkg;

  localparam int DEFAULT_DATA_W = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOCK0 = 2'd1;
  localparam logic [1:0] ST_LOCK1 = 2'd2;

  typedef struct packed {
    logic                      last;
    logic [DEFAULT_DATA_W-1:0] data;
  } beat_t;

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry synchronous FIFO. The head entry is a register that drives the
// output directly, so consumers never see a combinational path through the
// FIFO. A push into a full FIFO is refused even if a pop happens that cycle.
module stream_fifo2
  import stream_pkg::*;
#(
  parameter int W = DEFAULT_DATA_W + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] head;
  logic [W-1:0] tail;
  logic [1:0]   count;
  logic         do_push;
  logic         do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = head;

  // Shift-register style storage: head is always the oldest entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count == 2'd0) head <= din;
          else               tail <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          // Only reachable with exactly one entry: replace it in place.
          head <= din;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/stream_demux.sv
// 1:2 valid/ready byte-stream demultiplexer. The destination is chosen from
// s_sel on the first beat of a packet and held until the beat carrying
// s_last, so a packet never straddles both outputs. Each output is buffered
// by its own two-entry FIFO, and per-port counters track accepted beats.
module stream_demux
  import stream_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  input  logic              s_sel,
  output logic              m0_valid,
  input  logic              m0_ready,
  output logic [DATA_W-1:0] m0_data,
  output logic              m0_last,
  output logic              m1_valid,
  input  logic              m1_ready,
  output logic [DATA_W-1:0] m1_data,
  output logic              m1_last,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1
);

  logic [1:0] state;
  logic [1:0] state_next;
  logic       target;
  logic       accept;
  logic       full0;
  logic       full1;
  logic       empty0;
  logic       empty1;

  // Destination port: free choice in IDLE, pinned while a packet is open.
  always_comb begin
    target = s_sel;
    case (state)
      ST_LOCK0: target = 1'b0;
      ST_LOCK1: target = 1'b1;
      default:  target = s_sel;
    endcase
  end

  assign s_ready = !rst && !(target ? full1 : full0);
  assign accept  = s_valid && s_ready;

  // Packet lock: open on a non-final first beat, close on any final beat.
  always_comb begin
    state_next = state;
    if (accept) begin
      if (s_last)                state_next = ST_IDLE;
      else if (state == ST_IDLE) state_next = target ? ST_LOCK1 : ST_LOCK0;
    end
  end

  // State register for the packet lock.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Accepted-beat counters, wrapping naturally at their width.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else if (accept) begin
      if (target) cnt1 <= cnt1 + 1'b1;
      else        cnt0 <= cnt0 + 1'b1;
    end
  end

  assign m0_valid = !empty0;
  assign m1_valid = !empty1;

  stream_fifo2 #(.W(DATA_W + 1)) u_fifo0 (
    .clk   (clk),
    .rst   (rst),
    .push  (accept && !target),
    .pop   (m0_valid && m0_ready),
    .din   ({s_last, s_data}),
    .dout  ({m0_last, m0_data}),
    .full  (full0),
    .empty (empty0)
  );

  stream_fifo2 #(.W(DATA_W + 1)) u_fifo1 (
    .clk   (clk),
    .rst   (rst),
    .push  (accept && target),
    .pop   (m1_valid && m1_ready),
    .din   ({s_last, s_data}),
    .dout  ({m1_last, m1_data}),
    .full  (full1),
    .empty (empty1)
  );

endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench for stream_demux. A queue-based model of the two
// output buffers and the packet lock predicts every output each cycle;
// directed scenarios add hand-computed expectations on top.
module tb_stream_demux;
  import stream_pkg::*;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;
  localparam int BOUND  = 100;

  logic              clk;
  logic              rst;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              s_sel;
  logic              m0_valid;
  logic              m0_ready;
  logic [DATA_W-1:0] m0_data;
  logic              m0_last;
  logic              m1_valid;
  logic              m1_ready;
  logic [DATA_W-1:0] m1_data;
  logic              m1_last;
  logic [CNT_W-1:0]  cnt0;
  logic [CNT_W-1:0]  cnt1;

  int n_checks;
  int n_fail;
  bit checking;
  bit rand_ready;

  beat_t q0[$];
  beat_t q1[$];
  bit    locked;
  bit    lock_port;
  int    mc0;
  int    mc1;

  stream_demux #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .s_sel    (s_sel),
    .m0_valid (m0_valid),
    .m0_ready (m0_ready),
    .m0_data  (m0_data),
    .m0_last  (m0_last),
    .m1_valid (m1_valid),
    .m1_ready (m1_ready),
    .m1_data  (m1_data),
    .m1_last  (m1_last),
    .cnt0     (cnt0),
    .cnt1     (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: each edge, a full target refuses the beat, pops come off the
  // front of a queue, accepted beats join the back of their port's queue.
  always @(posedge clk) begin
    bit    tgt;
    bit    acc;
    beat_t b;
    if (rst) begin
      q0.delete();
      q1.delete();
      locked    = 1'b0;
      lock_port = 1'b0;
      mc0       = 0;
      mc1       = 0;
    end else begin
      tgt = locked ? lock_port : s_sel;
      acc = s_valid && ((tgt ? q1.size() : q0.size()) < 2);
      if (m0_ready && q0.size() > 0) void'(q0.pop_front());
      if (m1_ready && q1.size() > 0) void'(q1.pop_front());
      if (acc) begin
        b.last = s_last;
        b.data = s_data;
        if (tgt) begin
          q1.push_back(b);
          mc1 = (mc1 + 1) % (1 << CNT_W);
        end else begin
          q0.push_back(b);
          mc0 = (mc0 + 1) % (1 << CNT_W);
        end
        locked    = !s_last;
        lock_port = tgt;
      end
    end
  end

  // Compare every DUT output against the model away from the clock edge.
  always @(negedge clk) begin
    bit tgt;
    if (checking) begin
      tgt = locked ? lock_port : s_sel;
      checkOutput("s_ready", 32'(s_ready),
                  32'(!rst && ((tgt ? q1.size() : q0.size()) < 2)));
      checkOutput("m0_valid", 32'(m0_valid), 32'(q0.size() > 0));
      checkOutput("m1_valid", 32'(m1_valid), 32'(q1.size() > 0));
      if (q0.size() > 0) begin
        checkOutput("m0_data", 32'(m0_data), 32'(q0[0].data));
        checkOutput("m0_last", 32'(m0_last), 32'(q0[0].last));
      end
      if (q1.size() > 0) begin
        checkOutput("m1_data", 32'(m1_data), 32'(q1[0].data));
        checkOutput("m1_last", 32'(m1_last), 32'(q1[0].last));
      end
      checkOutput("cnt0", 32'(cnt0), 32'(mc0));
      checkOutput("cnt1", 32'(cnt1), 32'(mc1));
    end
  end

  // Random consumer readiness during the soak phase.
  always @(negedge clk) begin
    if (rand_ready) begin
      m0_ready = ($urandom_range(0, 3) != 0);
      m1_ready = ($urandom_range(0, 2) != 0);
    end
  end

  // Offer one beat and hold it until accepted; returns cycles spent stalled.
  task automatic applyStimulus(input bit sel, input logic [7:0] data,
                               input bit last, output int waited);
    bit done;
    s_valid = 1'b1;
    s_sel   = sel;
    s_data  = data;
    s_last  = last;
    waited  = 0;
    done    = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (s_ready) begin
        done = 1'b1;
        @(posedge clk);
        #1;
      end else begin
        waited++;
        if (waited > BOUND) begin
          checkOutput("accept_timeout", 32'(waited), 32'(BOUND));
          done = 1'b1;
        end
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    n_checks   = 0;
    n_fail     = 0;
    checking   = 1'b0;
    rand_ready = 1'b0;
    rst        = 1'b1;
    s_valid    = 1'b0;
    s_sel      = 1'b0;
    s_data     = '0;
    s_last     = 1'b0;
    m0_ready   = 1'b1;
    m1_ready   = 1'b1;
    idle(3);
    checking = 1'b1;
    checkOutput("rst_m0_valid", 32'(m0_valid), 32'd0);
    checkOutput("rst_m0_data", 32'(m0_data), 32'd0);
    checkOutput("rst_m1_last", 32'(m1_last), 32'd0);
    checkOutput("rst_cnt0", 32'(cnt0), 32'd0);
    checkOutput("rst_s_ready", 32'(s_ready), 32'd0);
    rst = 1'b0;
    idle(1);

    $display("[TB] single-beat packets");
    applyStimulus(1'b0, 8'hA5, 1'b1, w);
    checkOutput("lat_m0_valid", 32'(m0_valid), 32'd1);
    checkOutput("lat_m0_data", 32'(m0_data), 32'hA5);
    checkOutput("lat_m1_valid", 32'(m1_valid), 32'd0);
    applyStimulus(1'b1, 8'h3C, 1'b1, w);
    checkOutput("lat_m1_data", 32'(m1_data), 32'h3C);
    idle(2);
    checkOutput("single_cnt0", 32'(cnt0), 32'd1);
    checkOutput("single_cnt1", 32'(cnt1), 32'd1);

    $display("[TB] packet lock");
    applyStimulus(1'b1, 8'h10, 1'b0, w);
    applyStimulus(1'b0, 8'h11, 1'b0, w);
    applyStimulus(1'b1, 8'h12, 1'b0, w);
    applyStimulus(1'b0, 8'h13, 1'b1, w);
    checkOutput("lock_m0_valid", 32'(m0_valid), 32'd0);
    idle(4);
    // One beat from the single-beat test plus the four of this packet.
    checkOutput("lock_cnt1", 32'(cnt1), 32'd5);
    checkOutput("lock_cnt0", 32'(cnt0), 32'd1);

    $display("[TB] backpressure on port 1");
    m1_ready = 1'b0;
    applyStimulus(1'b1, 8'h01, 1'b0, w);
    checkOutput("bp_wait1", 32'(w), 32'd0);
    applyStimulus(1'b1, 8'h02, 1'b0, w);
    checkOutput("bp_wait2", 32'(w), 32'd0);
    fork
      applyStimulus(1'b1, 8'h03, 1'b1, w);
      begin
        repeat (3) @(negedge clk);
        checkOutput("bp_stalled", 32'(s_ready), 32'd0);
        m1_ready = 1'b1;
      end
    join
    checkOutput("bp_wait3", 32'(w), 32'd3);
    idle(4);

    $display("[TB] independent ports");
    m1_ready = 1'b0;
    applyStimulus(1'b1, 8'h21, 1'b1, w);
    applyStimulus(1'b1, 8'h22, 1'b1, w);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 8'h40 + 8'(i), (i == 3), w);
      checkOutput("indep_wait", 32'(w), 32'd0);
    end
    checkOutput("indep_m1_held", 32'(m1_valid), 32'd1);
    m1_ready = 1'b1;
    idle(4);

    $display("[TB] reset mid-packet");
    m0_ready = 1'b0;
    applyStimulus(1'b0, 8'h50, 1'b0, w);
    applyStimulus(1'b0, 8'h51, 1'b0, w);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_ready_low", 32'(s_ready), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("midrst_m0_valid", 32'(m0_valid), 32'd0);
    checkOutput("midrst_cnt0", 32'(cnt0), 32'd0);
    checkOutput("midrst_s_ready", 32'(s_ready), 32'd0);
    rst      = 1'b0;
    m0_ready = 1'b1;
    applyStimulus(1'b1, 8'h52, 1'b1, w);
    checkOutput("midrst_m1_valid", 32'(m1_valid), 32'd1);
    checkOutput("midrst_m0_quiet", 32'(m0_valid), 32'd0);
    idle(2);

    $display("[TB] counter wrap");
    for (int i = 1; i <= 17; i++) begin
      applyStimulus(1'b0, 8'(i), 1'b1, w);
      if (i == 15) checkOutput("wrap_15", 32'(cnt0), 32'hF);
      if (i == 16) checkOutput("wrap_16", 32'(cnt0), 32'h0);
      if (i == 17) checkOutput("wrap_17", 32'(cnt0), 32'h1);
    end
    idle(3);

    $display("[TB] randomized traffic");
    rand_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0), w);
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
    end
    rand_ready = 1'b0;
    m0_ready   = 1'b1;
    m1_ready   = 1'b1;
    idle(5);
    checkOutput("drain_m0", 32'(m0_valid), 32'd0);
    checkOutput("drain_m1", 32'(m1_valid), 32'd0);

    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
